// File: rtl/cache_unit.sv
// 3-way write-back/write-allocate data cache with main-memory model; hits in 0 stall cycles, rd_data one cycle later.
// Misses stall via combinational miss for MEM_DELAY+2 (clean) or 2*MEM_DELAY+2 (dirty) cycles; define CACHE_LRU_EN for true LRU, else FIFO.
module cache_unit #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 9,
  parameter int WAY_CNT       = 3,
  parameter int MEM_DELAY     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss
);
  localparam int SETS      = 1 << SET_ADDR_LEN;
  localparam int LINE_BITS = 32 << LINE_ADDR_LEN;
  localparam int MEM_LINES = 1 << (SET_ADDR_LEN + TAG_ADDR_LEN);
  localparam int WAY_W     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam int CNT_W     = $clog2(MEM_DELAY + 1);
  localparam int TAG_LO    = LINE_ADDR_LEN + SET_ADDR_LEN + 2;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic                      valid [WAY_CNT][SETS];
  logic                      dirty [WAY_CNT][SETS];
  logic [TAG_ADDR_LEN-1:0]   tags  [WAY_CNT][SETS];
  logic [LINE_BITS-1:0]      lines [WAY_CNT][SETS];
  logic [LINE_BITS-1:0]      mem   [MEM_LINES];
  logic [WAY_W-1:0]          vic_way, victim, hit_way;
  logic [TAG_ADDR_LEN-1:0]   vic_tag, fill_tag;
  logic [SET_ADDR_LEN-1:0]   fill_set;
  logic                      hit, found, req, xfer_done;

  logic [LINE_ADDR_LEN-1:0]  req_off;
  logic [SET_ADDR_LEN-1:0]   req_set;
  logic [TAG_ADDR_LEN-1:0]   req_tag;
  logic                      unused_addr_bits;

  assign req_off          = addr[LINE_ADDR_LEN+1:2];
  assign req_set          = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign req_tag          = addr[TAG_LO+TAG_ADDR_LEN-1:TAG_LO];
  assign unused_addr_bits = ^{addr[31:TAG_LO+TAG_ADDR_LEN], addr[1:0]};
  assign req              = rd_req | wr_req;
  assign xfer_done        = (cnt == CNT_W'(MEM_DELAY - 1));

`ifdef CACHE_LRU_EN
  // Age 0 = most recent; reset marks every way oldest so fills build a clean ordering.
  logic [WAY_W-1:0] age [WAY_CNT][SETS];
  logic [WAY_W-1:0] best_age, touch_way;
  logic [SET_ADDR_LEN-1:0] touch_set;
  logic touch_en;

  assign touch_en  = (state == IDLE && req && hit) || state == SWAP_IN_OK;
  assign touch_way = (state == SWAP_IN_OK) ? vic_way : hit_way;
  assign touch_set = (state == SWAP_IN_OK) ? fill_set : req_set;
`else
  logic [WAY_W-1:0] fifo_ptr [SETS];
`endif

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++)
      if (valid[w][req_set] && tags[w][req_set] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  always_comb begin
    found  = 1'b0;
    victim = '0;
`ifdef CACHE_LRU_EN
    best_age = age[0][req_set];
    for (int w = 1; w < WAY_CNT; w++)
      if (age[w][req_set] > best_age) begin
        best_age = age[w][req_set];
        victim   = WAY_W'(w);
      end
`else
    victim = fifo_ptr[req_set];
`endif
    for (int w = WAY_CNT - 1; w >= 0; w--)
      if (!valid[w][req_set]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (req && !hit)
                    state_nxt = (valid[victim][req_set] && dirty[victim][req_set]) ? SWAP_OUT : SWAP_IN;
      SWAP_OUT:   if (xfer_done) state_nxt = SWAP_IN;
      SWAP_IN:    if (xfer_done) state_nxt = SWAP_IN_OK;
      SWAP_IN_OK: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    miss = req && (state != IDLE || !hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      rd_data  <= '0;
      vic_way  <= '0;
      vic_tag  <= '0;
      fill_tag <= '0;
      fill_set <= '0;
      for (int s = 0; s < SETS; s++) begin
`ifndef CACHE_LRU_EN
        fifo_ptr[s] <= '0;
`endif
        for (int w = 0; w < WAY_CNT; w++) begin
          valid[w][s] <= 1'b0;
          dirty[w][s] <= 1'b0;
`ifdef CACHE_LRU_EN
          age[w][s]   <= WAY_W'(WAY_CNT - 1);
`endif
        end
      end
    end else begin
      cnt <= (state_nxt == state && state != IDLE) ? cnt + 1'b1 : '0;
      if (state == IDLE && req) begin
        if (hit) begin
          if (wr_req) dirty[hit_way][req_set] <= 1'b1;
          else        rd_data <= lines[hit_way][req_set][32*req_off +: 32];
        end else begin
          // Latch the miss context so the refill finishes even if the request drops.
          vic_way  <= victim;
          vic_tag  <= tags[victim][req_set];
          fill_tag <= req_tag;
          fill_set <= req_set;
        end
      end
      if (state == SWAP_IN_OK) begin
        valid[vic_way][fill_set] <= 1'b1;
        dirty[vic_way][fill_set] <= 1'b0;
`ifndef CACHE_LRU_EN
        fifo_ptr[fill_set] <= (fifo_ptr[fill_set] == WAY_W'(WAY_CNT - 1)) ? '0 : fifo_ptr[fill_set] + 1'b1;
`endif
      end
`ifdef CACHE_LRU_EN
      if (touch_en)
        for (int w = 0; w < WAY_CNT; w++)
          if (WAY_W'(w) == touch_way)
            age[w][touch_set] <= '0;
          else if (age[w][touch_set] < age[touch_way][touch_set])
            age[w][touch_set] <= age[w][touch_set] + 1'b1;
`endif
    end
  end

  // Line data, tags and main memory carry no reset; writes are suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == IDLE && req && hit && wr_req)
        lines[hit_way][req_set][32*req_off +: 32] <= wr_data;
      if (state == SWAP_IN_OK) begin
        lines[vic_way][fill_set] <= mem[{fill_tag, fill_set}];
        tags[vic_way][fill_set]  <= fill_tag;
      end
      if (state == SWAP_OUT && xfer_done)
        mem[{vic_tag, fill_set}] <= lines[vic_way][fill_set];
    end
  end
endmodule

// File: tb/tb_cache_unit.sv
// Directed bench for cache_unit: stall counts, load data, eviction write-back, replacement and reset.
module tb_cache_unit;
  logic        clk, rst, rd_req, wr_req, miss;
  logic [31:0] addr, wr_data, rd_data;
  int total = 0;
  int bad   = 0;

  cache_unit dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .rd_data(rd_data), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request, count stall cycles until miss drops (-1 on timeout), then let the hit edge happen.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d, output int stalls);
    addr = a; rd_req = rd; wr_req = wr; wr_data = d;
    #1;
    stalls = 0;
    while (miss && stalls < 100) begin
      cycle();
      stalls++;
    end
    if (miss) stalls = -1;
    cycle();
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic do_reset();
    rd_req = 1'b0; wr_req = 1'b0; rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int s;
    do_reset();
    #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL reset_miss got=%b exp=0", miss); end
    access(32'h0, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 10) begin bad++; $display("FAIL cold_read_stall got=%0d exp=10", s); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL cold_read_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_write_alloc();
    int s;
    access(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, s);
    total++; if (s !== 10) begin bad++; $display("FAIL wr_alloc_stall got=%0d exp=10", s); end
    access(32'h10, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 0) begin bad++; $display("FAIL wr_hit_read_stall got=%0d exp=0", s); end
    total++; if (rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hit_read_data got=%h exp=deadbeef", rd_data); end
    access(32'h14, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 0 || rd_data !== 32'h0) begin bad++; $display("FAIL same_line_word got=%0d/%h exp=0/0", s, rd_data); end
    access(32'h10, 1'b1, 1'b1, 32'h0BAD_F00D, s);
    total++; if (s !== 0 || rd_data !== 32'h0) begin bad++; $display("FAIL rd_wr_both got=%0d/%h exp=0/0", s, rd_data); end
    access(32'h10, 1'b1, 1'b0, 32'h0, s);
    total++; if (rd_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL rd_wr_both_readback got=%h exp=0badf00d", rd_data); end
  endtask

  task automatic test_eviction();
    int s;
    logic [31:0] a [3] = '{32'h000, 32'h100, 32'h200};
    logic [31:0] v [3] = '{32'hAAAA_0000, 32'hBBBB_0100, 32'hCCCC_0200};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      access(a[i], 1'b0, 1'b1, v[i], s);
      total++; if (s !== 10) begin bad++; $display("FAIL fill_stall[%0d] got=%0d exp=10", i, s); end
    end
    access(32'h300, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 18) begin bad++; $display("FAIL dirty_evict_stall got=%0d exp=18", s); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL dirty_evict_data got=%h exp=0", rd_data); end
    access(32'h000, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 18 || rd_data !== 32'hAAAA_0000) begin bad++; $display("FAIL writeback_000 got=%0d/%h exp=18/aaaa0000", s, rd_data); end
    access(32'h100, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 18 || rd_data !== 32'hBBBB_0100) begin bad++; $display("FAIL writeback_100 got=%0d/%h exp=18/bbbb0100", s, rd_data); end
  endtask

  task automatic test_replacement();
    int s, exp_s;
    logic [31:0] seq [4] = '{32'h000, 32'h100, 32'h200, 32'h000};
    int seq_s [4] = '{10, 10, 10, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(seq[i], 1'b1, 1'b0, 32'h0, s);
      total++; if (s !== seq_s[i]) begin bad++; $display("FAIL repl_seq[%0d] got=%0d exp=%0d", i, s, seq_s[i]); end
    end
    access(32'h300, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 10) begin bad++; $display("FAIL repl_300 got=%0d exp=10", s); end
`ifdef CACHE_LRU_EN
    exp_s = 0;
`else
    exp_s = 10;
`endif
    access(32'h000, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== exp_s) begin bad++; $display("FAIL repl_000 got=%0d exp=%0d", s, exp_s); end
  endtask

  task automatic test_reset_mid_refill();
    int s;
    do_reset();
    access(32'h040, 1'b0, 1'b1, 32'h1234, s);
    access(32'h040, 1'b1, 1'b0, 32'h0, s);
    total++; if (rd_data !== 32'h1234) begin bad++; $display("FAIL pre_reset_data got=%h exp=1234", rd_data); end
    addr = 32'h0; rd_req = 1'b1; wr_req = 1'b0;
    cycle(); cycle(); cycle();
    rd_req = 1'b0; rst = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL mid_reset_rd_data got=%h exp=0", rd_data); end
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL mid_reset_miss got=%b exp=0", miss); end
    access(32'h000, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 10) begin bad++; $display("FAIL after_reset_miss got=%0d exp=10", s); end
    access(32'h040, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 10 || rd_data !== 32'h0) begin bad++; $display("FAIL dirty_discarded got=%0d/%h exp=10/0", s, rd_data); end
  endtask

  task automatic test_idle();
    int s;
    access(32'h040, 1'b0, 1'b1, 32'h55AA, s);
    access(32'h040, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 0 || rd_data !== 32'h55AA) begin bad++; $display("FAIL idle_setup got=%0d/%h exp=0/55aa", s, rd_data); end
    for (int i = 0; i < 4; i++) begin
      addr = $urandom; rd_req = 1'b0; wr_req = 1'b0; wr_data = $urandom;
      #1;
      total++; if (miss !== 1'b0) begin bad++; $display("FAIL idle_miss[%0d] got=%b exp=0", i, miss); end
      cycle();
    end
    total++; if (rd_data !== 32'h55AA) begin bad++; $display("FAIL idle_rd_hold got=%h exp=55aa", rd_data); end
    access(32'h040, 1'b1, 1'b0, 32'h0, s);
    total++; if (s !== 0 || rd_data !== 32'h55AA) begin bad++; $display("FAIL idle_no_change got=%0d/%h exp=0/55aa", s, rd_data); end
  endtask

  initial begin
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
    test_reset();
    test_write_alloc();
    test_eviction();
    test_replacement();
    test_reset_mid_refill();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
